// File: rtl/sppf_pkg.sv
// Shared types and helpers for the time-multiplexed SPPF stage sequencer.
package sppf_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_CV1  = 3'd1,
    PH_MP1  = 3'd2,
    PH_MP2  = 3'd3,
    PH_MP3  = 3'd4,
    PH_CV2  = 3'd5
  } phase_e;

  localparam logic [1:0] SLOT_CV1 = 2'd0;
  localparam logic [1:0] SLOT_Y1  = 2'd1;
  localparam logic [1:0] SLOT_Y2  = 2'd2;
  localparam logic [1:0] SLOT_Y3  = 2'd3;

  // Engine selects driven while a phase is active.
  typedef struct packed {
    logic [1:0] src;
    logic [1:0] dst;
    logic       conv_sel;
  } sel_t;

  // Selects for a phase; pool selects stay at 0 outside the pool phases.
  function automatic sel_t phase_sel(input phase_e ph);
    sel_t s;
    s = '0;
    case (ph)
      PH_MP1: begin s.src = SLOT_CV1; s.dst = SLOT_Y1; end
      PH_MP2: begin s.src = SLOT_Y1;  s.dst = SLOT_Y2; end
      PH_MP3: begin s.src = SLOT_Y2;  s.dst = SLOT_Y3; end
      PH_CV2: s.conv_sel = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

  // Concat slot filled when the phase completes (CV2 only reads).
  function automatic logic [3:0] slot_mask(input phase_e ph);
    case (ph)
      PH_CV1:  return 4'b0001 << SLOT_CV1;
      PH_MP1:  return 4'b0001 << SLOT_Y1;
      PH_MP2:  return 4'b0001 << SLOT_Y2;
      PH_MP3:  return 4'b0001 << SLOT_Y3;
      default: return 4'b0000;
    endcase
  endfunction

  // Run order cv1 -> mp1 -> mp2 -> mp3 -> cv2 -> idle.
  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      PH_CV1:  return PH_MP1;
      PH_MP1:  return PH_MP2;
      PH_MP2:  return PH_MP3;
      PH_MP3:  return PH_CV2;
      default: return PH_IDLE;
    endcase
  endfunction

  function automatic logic is_conv_phase(input phase_e ph);
    return (ph == PH_CV1) || (ph == PH_CV2);
  endfunction

  function automatic logic is_pool_phase(input phase_e ph);
    return (ph == PH_MP1) || (ph == PH_MP2) || (ph == PH_MP3);
  endfunction

endpackage

// File: rtl/sppf_phase_timer.sv
// Per-phase wait counter: cleared on phase entry, counts idle wait cycles,
// flags expiry once the count reaches TIMEOUT and then holds there.
module sppf_phase_timer #(
  parameter int TIMEOUT = 65535,
  parameter int TMO_W   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == TMO_W'(TIMEOUT));

  // Next count: clear wins, otherwise count up and stop at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !expired)
      cnt_d = cnt_q + TMO_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sppf_ctrl.sv
// Sequencer for a time-multiplexed SPPF stage: one shared 1x1 conv engine and
// one shared 5x5 maxpool engine, four concat slots, run cv1->mp1->mp2->mp3->cv2.
module sppf_ctrl
  import sppf_pkg::*;
#(
  parameter int TIMEOUT = 65535,
  parameter int TMO_W   = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       phase,
  output logic             conv_start,
  output logic             conv_sel,
  input  logic             conv_done,
  output logic             pool_start,
  output logic [1:0]       pool_src,
  output logic [1:0]       pool_dst,
  input  logic             pool_done,
  output logic [3:0]       cat_valid,
  output logic [CNT_W-1:0] cycles
);

  phase_e           phase_q, phase_d;
  logic             conv_start_q, conv_start_d;
  logic             pool_start_q, pool_start_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             conv_sel_q, conv_sel_d;
  logic [1:0]       pool_src_q, pool_src_d;
  logic [1:0]       pool_dst_q, pool_dst_d;
  logic [3:0]       cat_valid_q, cat_valid_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  logic busy_w;
  logic eng_done;
  logic counted_done;
  logic tmr_clr, tmr_en, tmr_expired;
  sel_t sel_d;

  sppf_phase_timer #(
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  assign busy_w = (phase_q != PH_IDLE);

  // Done from the engine owning the current phase; the other engine is ignored.
  // A done coinciding with the phase's start pulse is too early to be real.
  always_comb begin
    eng_done = 1'b0;
    if (is_conv_phase(phase_q))
      eng_done = conv_done;
    else if (is_pool_phase(phase_q))
      eng_done = pool_done;
    counted_done = eng_done && !(conv_start_q || pool_start_q);
  end

  // Next phase, status flags and counters, prioritised abort > timeout > done > start.
  always_comb begin
    phase_d     = phase_q;
    done_d      = 1'b0;
    err_d       = err_q;
    cat_valid_d = cat_valid_q;
    cycles_d    = cycles_q;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    if (busy_w && (cycles_q != '1))
      cycles_d = cycles_q + CNT_W'(1);

    if (!busy_w) begin
      if (start && !abort) begin
        phase_d     = PH_CV1;
        cat_valid_d = '0;
        err_d       = 1'b0;
        // The accept cycle opens the run, so the final count equals the
        // start-to-done latency.
        cycles_d    = CNT_W'(1);
        tmr_clr     = 1'b1;
      end
    end else if (abort) begin
      phase_d = PH_IDLE;
    end else if (tmr_expired) begin
      phase_d = PH_IDLE;
      err_d   = 1'b1;
      done_d  = 1'b1;
    end else if (counted_done) begin
      cat_valid_d = cat_valid_q | slot_mask(phase_q);
      phase_d     = next_phase(phase_q);
      tmr_clr     = 1'b1;
      if (phase_q == PH_CV2)
        done_d = 1'b1;
    end else begin
      tmr_en = 1'b1;
    end

    // Selects follow the phase being entered and stay put while it lasts.
    sel_d        = phase_sel(phase_d);
    conv_sel_d   = sel_d.conv_sel;
    pool_src_d   = sel_d.src;
    pool_dst_d   = sel_d.dst;
    conv_start_d = (phase_d != phase_q) && is_conv_phase(phase_d);
    pool_start_d = (phase_d != phase_q) && is_pool_phase(phase_d);
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= PH_IDLE;
      conv_start_q <= 1'b0;
      pool_start_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      conv_sel_q   <= 1'b0;
      pool_src_q   <= '0;
      pool_dst_q   <= '0;
      cat_valid_q  <= '0;
      cycles_q     <= '0;
    end else begin
      phase_q      <= phase_d;
      conv_start_q <= conv_start_d;
      pool_start_q <= pool_start_d;
      done_q       <= done_d;
      err_q        <= err_d;
      conv_sel_q   <= conv_sel_d;
      pool_src_q   <= pool_src_d;
      pool_dst_q   <= pool_dst_d;
      cat_valid_q  <= cat_valid_d;
      cycles_q     <= cycles_d;
    end
  end

  assign busy       = busy_w;
  assign done       = done_q;
  assign err        = err_q;
  assign phase      = phase_q;
  assign conv_start = conv_start_q;
  assign pool_start = pool_start_q;
  assign conv_sel   = conv_sel_q;
  assign pool_src   = pool_src_q;
  assign pool_dst   = pool_dst_q;
  assign cat_valid  = cat_valid_q;
  assign cycles     = cycles_q;

endmodule
